// File: rtl/bf16_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : bf16_pkg                                                     |
// | Description : BF16 field constants and classification helpers, shared by   |
// |               the divider, multiplier and adder datapaths.                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package bf16_pkg;

    localparam int           BF16_W  = 16;
    localparam int           EXP_MSB = 14;
    localparam int           EXP_LSB = 7;
    localparam logic [7:0]   EXP_INF = 8'hFF;

    // A zero exponent covers true zero and denormals, which the datapath flushes to zero.
    function automatic logic is_zero(input logic [BF16_W-1:0] r);
        return (r[EXP_MSB:EXP_LSB] == 8'h00);
    endfunction

    // The exception path reuses the all-ones exponent, so a flagged result is never reported as inf.
    function automatic logic is_inf(input logic [BF16_W-1:0] r, input logic exc);
        return (r[EXP_MSB:EXP_LSB] == EXP_INF) && !exc;
    endfunction

endpackage : bf16_pkg
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sync_fifo_fwft                                               |
// | Description : Generic synchronous show-ahead FIFO. Head entry is visible   |
// |               on o_data whenever the FIFO is not empty.                    |
// | Ports       : i_clk, i_rst (sync, active high), i_push/i_data write side,  |
// |               i_pop read side, o_data head, o_count occupancy,             |
// |               o_count_nxt next-state occupancy, o_full, o_empty.           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sync_fifo_fwft #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_data,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH):0]     o_count_nxt,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_pop  = i_pop  && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are qualified by count.
    always_ff @(posedge i_clk) begin
        if (w_push) mem_q[wr_ptr_q] <= i_data;
    end

    assign o_data      = mem_q[rd_ptr_q];
    assign o_count     = count_q;
    assign o_count_nxt = count_d;

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/bf16_div_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bf16_div_result_fifo                                         |
// | Description : Result buffer behind the BF16 divider. Captures results,     |
// |               classifies them at write, presents them with valid/ready,    |
// |               returns an issue credit and counts dropped results.          |
// | Ports       : i_vld/i_res/i_exception from divider; o_issue_ok to issuer;  |
// |               o_vld/i_rdy/o_res/o_exception/o_zero/o_inf to consumer;      |
// |               o_count occupancy; o_drop_cnt, o_overflow drop status.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module bf16_div_result_fifo
    import bf16_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int DIV_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_vld,
    input  logic [BF16_W-1:0]       i_res,
    input  logic                    i_exception,
    output logic                    o_issue_ok,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic [BF16_W-1:0]       o_res,
    output logic                    o_exception,
    output logic                    o_zero,
    output logic                    o_inf,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic [CNT_W-1:0]        o_drop_cnt,
    output logic                    o_overflow
);

    localparam int ENTRY_W = BF16_W + 3;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] w_wr_entry;
    logic [ENTRY_W-1:0] w_head;
    logic [CW-1:0]      w_count_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_drop;

    logic               issue_ok_q;
    logic [CNT_W-1:0]   drop_cnt_q;
    logic               overflow_q;

    // Entry layout {inf, zero, exception, res}: classification is done once, on the way in.
    assign w_wr_entry = {is_inf(i_res, i_exception), is_zero(i_res), i_exception, i_res};

    assign o_vld  = !w_empty;
    assign w_pop  = o_vld && i_rdy;
    assign w_drop = i_vld && w_full && !w_pop;

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (i_vld),
        .i_pop       (w_pop),
        .i_data      (w_wr_entry),
        .o_data      (w_head),
        .o_count     (o_count),
        .o_count_nxt (w_count_nxt),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            issue_ok_q <= 1'b1;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Credit is granted only when every in-flight divider result still has a slot.
            issue_ok_q <= (int'(w_count_nxt) + DIV_LAT) < DEPTH;
            if (w_drop) begin
                overflow_q <= 1'b1;
                if (!(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    // Head fields are forced to zero when empty so stale RAM contents never leak out.
    assign o_res       = o_vld ? w_head[BF16_W-1:0] : '0;
    assign o_exception = o_vld && w_head[BF16_W];
    assign o_zero      = o_vld && w_head[BF16_W+1];
    assign o_inf       = o_vld && w_head[BF16_W+2];

    assign o_issue_ok = issue_ok_q;
    assign o_drop_cnt = drop_cnt_q;
    assign o_overflow = overflow_q;

endmodule : bf16_div_result_fifo
`default_nettype wire
